router_pkt_fifo: RTL and testbench
==================================

Name: router_pkt_fifo

Overview:
- Parametrised packet-aware FIFO for the router output channels; one instance per destination port, between the register/FSM write side and the channel read side.
- Stores each beat with a header tag and tracks packet framing on the read side.
- Provides sof/eop/valid markers, occupancy, almost-full/almost-empty thresholds and error pulses, so downstream logic needs no tri-state or idle decoding.

Parameters:
- DATA_W, 8, data beat width (min 4).
- DEPTH, 16, entries; power of two, min 4.
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.
- CW, $clog2(DEPTH)+1, occupancy width (derived, not overridable).

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- soft_reset  in  1  synchronous flush (channel timeout)
- write_enb  in  1  write request
- sof_in  in  1  current write beat is a header
- data_in  in  DATA_W  write data
- read_enb  in  1  read request
- data_out  out  DATA_W  registered read data
- data_valid  out  1  data_out holds a beat popped last cycle
- sof_out  out  1  data_out is a header beat
- eop_out  out  1  data_out is last beat of packet (parity)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  threshold flag
- almost_empty  out  1  threshold flag
- count  out  CW  occupancy
- ovf_err  out  1  one-cycle pulse: write_enb while full
- udf_err  out  1  one-cycle pulse: read_enb while empty
- frame_err  out  1  one-cycle pulse: non-header beat popped with no packet open

Behaviour:
- Reset: resetn is the already-decided reset, synchronous, active-low; clock clk. All registers clear; outputs 0 except empty=1 and almost_empty=1. Memory contents are not reset.
- Priority: resetn > soft_reset > normal operation.
- soft_reset clears pointers, count, remaining-beat counter, data_valid, sof_out, eop_out and all error pulses. data_out holds its value. Any write or read in the same cycle is ignored.
- Write accepted when write_enb && !full. Stores {sof_in, data_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Read accepted when read_enb && !empty. Latency is one cycle: data_out/sof_out/eop_out/data_valid update at the next edge. data_valid is 0 in cycles with no accepted read; data_out holds its last value.
- Full/empty use the registered count only. Simultaneous write+read when full: read accepted, write refused, ovf_err pulses. When empty: write accepted, read refused, udf_err pulses (no same-cycle bypass). Otherwise both are accepted and count is unchanged.
- full, empty, almost_full, almost_empty are combinational from count.
- Read framing (remaining counter rem, width DATA_W-1):
  - Header popped: rem <= data[DATA_W-1:2] + 1 (payload + parity); sof_out=1.
  - Header popped with rem != 0: the old packet is abandoned, frame_err pulses, the new header is accepted.
  - Non-header popped with rem > 0: rem decrements; eop_out=1 when rem==1.
  - Non-header popped with rem == 0: frame_err pulses, beat is still output.
  - A header with length 0 gives a 2-beat packet (header + parity).

Decomposition:
- Package router_pkg:
  - LEN_MSB/LEN_LSB field constants (DATA_W-1 / 2).
  - Header-tagged entry typedef {hdr, data}.
  - Shared default DATA_W.
- Sub-module router_fifo_mem: dual-port register array, DEPTH x (DATA_W+1), synchronous write, combinational read at rd_ptr. Pointers, count, framing and flags stay in router_pkt_fifo.

Test Plan:
- Reset, then write header 0x0C (len 3) + 4 beats, then read 5 -> sof_out on first read; eop_out on 5th; data order exact; count returns 0; empty=1.
- Write 16 beats with DEPTH=16 -> full=1 and almost_full from count 14; 17th write gives ovf_err=1 for one cycle, count stays 16, and no data is overwritten.
- Simultaneous read+write at count 5 for 10 cycles -> count stays 5, pointers wrap, output sequence intact. Read+write when full -> only read accepted.
- Read while empty -> udf_err pulse, data_valid=0, data_out unchanged.
- soft_reset after 7 writes and mid-packet read -> next cycle count=0, empty=1, data_valid=0. New header 0x04 then reads framed correctly, with no frame_err.
- Pop a non-header beat first after flush (written with sof_in=0) -> frame_err=1, data_valid=1. Then header 0x00 + parity -> eop_out on the 2nd beat.

Source files
------------

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the router output-channel FIFO slice.
//   - ROUTER_DATA_W : default data beat width used across the router
//   - LEN_LSB       : lowest bit of the header length field
//   - LEN_MSB       : highest bit of the header length field (default width)
//   - len_msb()     : length-field MSB for an arbitrary beat width
//   - router_entry_t: header-tagged FIFO entry {hdr, data} at default width
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int ROUTER_DATA_W = 8;

    // Header beat layout: [DATA_W-1:2] payload length, [1:0] destination.
    localparam int LEN_LSB = 2;
    localparam int LEN_MSB = ROUTER_DATA_W - 1;

    function automatic int len_msb(input int data_w);
        return data_w - 1;
    endfunction

    typedef struct packed {
        logic                     hdr;
        logic [ROUTER_DATA_W-1:0] data;
    } router_entry_t;

endpackage

// File: rtl/router_fifo_mem.sv
// ---------------------------------------------------------------------------
// router_fifo_mem
//   Dual-port register array backing the packet FIFO. Synchronous write,
//   combinational read. Contents are never reset.
//   Ports:
//     clk      in  clock
//     i_we     in  write strobe
//     i_waddr  in  write address
//     i_wdata  in  write entry {hdr, data}
//     i_raddr  in  read address
//     o_rdata  out entry at i_raddr (combinational)
// ---------------------------------------------------------------------------
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// router_pkt_fifo
//   Packet-aware FIFO for one router output channel. Each beat is stored with
//   a header tag; the read side tracks packet framing and marks header and
//   last (parity) beats, flags framing errors, and reports occupancy.
//   Ports:
//     clk, resetn     clock, synchronous active-low reset
//     soft_reset      synchronous flush (channel timeout)
//     write_enb       write request; sof_in tags the beat as header
//     data_in         write data
//     read_enb        read request
//     data_out        registered read data (holds when no read)
//     data_valid      data_out holds a beat popped last cycle
//     sof_out/eop_out header / last-beat markers for data_out
//     full/empty      count == DEPTH / count == 0
//     almost_full     count >= AF_LEVEL
//     almost_empty    count <= AE_LEVEL
//     count           occupancy
//     ovf_err         pulse: write while full
//     udf_err         pulse: read while empty
//     frame_err       pulse: header abandoned an open packet, or a
//                     non-header beat popped with no packet open
// ---------------------------------------------------------------------------
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = ROUTER_DATA_W,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        soft_reset,
    input  logic                        write_enb,
    input  logic                        sof_in,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        read_enb,
    output logic [DATA_W-1:0]           data_out,
    output logic                        data_valid,
    output logic                        sof_out,
    output logic                        eop_out,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        ovf_err,
    output logic                        udf_err,
    output logic                        frame_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int RW      = DATA_W - 1;
    localparam int L_MSB   = len_msb(DATA_W);
    localparam int L_LSB   = LEN_LSB;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [RW-1:0]      r_rem;
    logic [DATA_W-1:0]  r_data_out;
    logic               r_data_valid;
    logic               r_sof_out;
    logic               r_eop_out;
    logic               r_ovf_err;
    logic               r_udf_err;
    logic               r_frame_err;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic               w_full;
    logic               w_empty;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic [DATA_W:0]    w_wr_entry;
    logic [DATA_W:0]    w_rd_entry;
    logic               w_rd_hdr;
    logic [DATA_W-1:0]  w_rd_data;
    logic [RW-1:0]      w_hdr_rem;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // soft_reset suppresses both sides so the flush cycle touches no state.
    assign w_wr_acc = write_enb && !w_full  && !soft_reset;
    assign w_rd_acc = read_enb  && !w_empty && !soft_reset;

    assign w_wr_entry = {sof_in, data_in};
    assign w_rd_hdr   = w_rd_entry[DATA_W];
    assign w_rd_data  = w_rd_entry[DATA_W-1:0];

    // Remaining beats after a header: payload length plus the parity beat.
    assign w_hdr_rem = {1'b0, w_rd_data[L_MSB:L_LSB]} + RW'(1);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (soft_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Error pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else if (soft_reset) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_ovf_err <= write_enb && w_full;
            r_udf_err <= read_enb  && w_empty;
        end
    end

    // ------------------------------------------------------------------
    // Read data path and packet framing
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_sof_out    <= 1'b0;
            r_eop_out    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rem        <= '0;
        end else if (soft_reset) begin
            // data_out deliberately holds across a flush.
            r_data_valid <= 1'b0;
            r_sof_out    <= 1'b0;
            r_eop_out    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rem        <= '0;
        end else if (w_rd_acc) begin
            r_data_out   <= w_rd_data;
            r_data_valid <= 1'b1;
            if (w_rd_hdr) begin
                // A new header always opens a packet; an unfinished one is
                // dropped and flagged.
                r_sof_out   <= 1'b1;
                r_eop_out   <= 1'b0;
                r_frame_err <= (r_rem != '0);
                r_rem       <= w_hdr_rem;
            end else if (r_rem != '0) begin
                r_sof_out   <= 1'b0;
                r_eop_out   <= (r_rem == RW'(1));
                r_frame_err <= 1'b0;
                r_rem       <= r_rem - RW'(1);
            end else begin
                // Orphan beat: still delivered, but flagged.
                r_sof_out   <= 1'b0;
                r_eop_out   <= 1'b0;
                r_frame_err <= 1'b1;
            end
        end else begin
            r_data_valid <= 1'b0;
            r_sof_out    <= 1'b0;
            r_eop_out    <= 1'b0;
            r_frame_err  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign sof_out      = r_sof_out;
    assign eop_out      = r_eop_out;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign count        = r_count;
    assign ovf_err      = r_ovf_err;
    assign udf_err      = r_udf_err;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_router_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_fifo
//   Directed scoreboard bench for router_pkt_fifo (DATA_W=8, DEPTH=16).
//   Stimulus pushes expected popped beats and expected status snapshots;
//   a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_router_pkt_fifo;

    logic       clk = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       sof_in;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sof_out;
    logic       eop_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       ovf_err;
    logic       udf_err;
    logic       frame_err;

    always #5 clk = ~clk;

    router_pkt_fifo #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .soft_reset   (soft_reset),
        .write_enb    (write_enb),
        .sof_in       (sof_in),
        .data_in      (data_in),
        .read_enb     (read_enb),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .sof_out      (sof_out),
        .eop_out      (eop_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err),
        .frame_err    (frame_err)
    );

    // Expected popped beat: {sof, eop, frame_err, data}
    logic [10:0] q_d[$];

    typedef struct packed {
        logic [4:0] cnt;
        logic       ovf;
        logic       udf;
        logic       vld;
        logic       dchk;
        logic [7:0] dout;
    } st_t;

    st_t   q_s[$];
    string q_n[$];

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [10:0] e;
        st_t         s;
        string       nm;
        logic        x_full, x_empty, x_af, x_ae;
        logic        bad;
        if (data_valid) begin
            n_tests++;
            if (q_d.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pop: got data=%h sof=%0b eop=%0b ferr=%0b, required no pop",
                         data_out, sof_out, eop_out, frame_err);
            end else begin
                e = q_d.pop_front();
                if ({sof_out, eop_out, frame_err, data_out} !== e) begin
                    n_fail++;
                    $display("FAIL pop_%h: got sof=%0b eop=%0b ferr=%0b data=%h, required sof=%0b eop=%0b ferr=%0b data=%h",
                             e[7:0], sof_out, eop_out, frame_err, data_out,
                             e[10], e[9], e[8], e[7:0]);
                end
            end
        end
        if (q_s.size() > 0) begin
            s  = q_s.pop_front();
            nm = q_n.pop_front();
            n_tests++;
            if (nm == "end") begin
                if (q_d.size() != 0) begin
                    n_fail++;
                    $display("FAIL end_drain: %0d expected pops outstanding, required 0", q_d.size());
                end
            end else begin
                x_full  = (s.cnt == 5'd16);
                x_empty = (s.cnt == 5'd0);
                x_af    = (s.cnt >= 5'd14);
                x_ae    = (s.cnt <= 5'd2);
                bad = (count !== s.cnt) || (full !== x_full) || (empty !== x_empty) ||
                      (almost_full !== x_af) || (almost_empty !== x_ae) ||
                      (ovf_err !== s.ovf) || (udf_err !== s.udf) ||
                      (data_valid !== s.vld) || (s.dchk && (data_out !== s.dout)) ||
                      (!s.vld && ((sof_out !== 1'b0) || (eop_out !== 1'b0) || (frame_err !== 1'b0)));
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s: got cnt=%0d f=%0b e=%0b af=%0b ae=%0b ovf=%0b udf=%0b vld=%0b dout=%h, required cnt=%0d f=%0b e=%0b af=%0b ae=%0b ovf=%0b udf=%0b vld=%0b dout=%h",
                             nm, count, full, empty, almost_full, almost_empty, ovf_err, udf_err,
                             data_valid, data_out, s.cnt, x_full, x_empty, x_af, x_ae,
                             s.ovf, s.udf, s.vld, s.dchk ? s.dout : data_out);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic s, input logic [7:0] d);
        write_enb = 1'b1;
        sof_in    = s;
        data_in   = d;
        tick();
        write_enb = 1'b0;
        sof_in    = 1'b0;
    endtask

    task automatic exp_pop(input logic s, input logic e, input logic f, input logic [7:0] d);
        q_d.push_back({s, e, f, d});
    endtask

    task automatic exp_st(input string nm, input int cnt, input logic ovf, input logic udf,
                          input logic vld, input logic dchk, input logic [7:0] dout);
        st_t s;
        s.cnt  = 5'(cnt);
        s.ovf  = ovf;
        s.udf  = udf;
        s.vld  = vld;
        s.dchk = dchk;
        s.dout = dout;
        q_s.push_back(s);
        q_n.push_back(nm);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        sof_in     = 1'b0;
        data_in    = '0;
        read_enb   = 1'b0;

        // Reset state
        tick();
        tick();
        exp_st("reset", 0, 0, 0, 0, 1, 8'h00);
        resetn = 1'b1;
        tick();

        // Packet: header 0x0C (len 3) + 3 payload + parity
        wr(1, 8'h0C);
        wr(0, 8'hA1);
        wr(0, 8'hA2);
        wr(0, 8'hA3);
        wr(0, 8'hA4);
        exp_st("pkt_loaded", 5, 0, 0, 0, 0, 8'h00);
        exp_pop(1, 0, 0, 8'h0C);
        exp_pop(0, 0, 0, 8'hA1);
        exp_pop(0, 0, 0, 8'hA2);
        exp_pop(0, 0, 0, 8'hA3);
        exp_pop(0, 1, 0, 8'hA4);
        read_enb = 1'b1;
        repeat (5) tick();
        read_enb = 1'b0;
        tick();
        exp_st("pkt_done", 0, 0, 0, 0, 1, 8'hA4);

        // Fill to full, thresholds
        for (int i = 0; i < 16; i++) begin
            wr(0, 8'(8'h10 + i));
            if (i == 12) exp_st("af_at_13", 13, 0, 0, 0, 0, 8'h00);
            if (i == 13) exp_st("af_at_14", 14, 0, 0, 0, 0, 8'h00);
            if (i == 15) exp_st("full_16", 16, 0, 0, 0, 0, 8'h00);
        end
        wr(0, 8'hFF);
        exp_st("ovf_pulse", 16, 1, 0, 0, 0, 8'h00);
        tick();
        exp_st("ovf_clear", 16, 0, 0, 0, 0, 8'h00);

        // Read+write while full: only the read is accepted
        write_enb = 1'b1;
        data_in   = 8'hEE;
        read_enb  = 1'b1;
        exp_pop(0, 0, 1, 8'h10);
        tick();
        write_enb = 1'b0;
        exp_st("full_rw", 15, 1, 0, 1, 0, 8'h00);

        // Drain; beats are orphans (no header) so frame_err accompanies each
        for (int k = 1; k <= 15; k++) exp_pop(0, 0, 1, 8'(8'h10 + k));
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 12) exp_st("ae_at_3", 3, 0, 0, 1, 0, 8'h00);
            if (k == 13) exp_st("ae_at_2", 2, 0, 0, 1, 0, 8'h00);
        end
        read_enb = 1'b0;
        tick();
        exp_st("drained", 0, 0, 0, 0, 1, 8'h1F);

        // Steady read+write at count 5 with pointer wrap
        wr(1, 8'hFC);
        for (int j = 0; j < 4; j++) wr(0, 8'(8'h30 + j));
        exp_st("rw_start", 5, 0, 0, 0, 0, 8'h00);
        write_enb = 1'b1;
        read_enb  = 1'b1;
        for (int j = 0; j < 10; j++) begin
            data_in = 8'(8'h34 + j);
            if (j == 0) exp_pop(1, 0, 0, 8'hFC);
            else        exp_pop(0, 0, 0, 8'(8'h30 + j - 1));
            tick();
            if (j == 0 || j == 9) exp_st("rw_steady", 5, 0, 0, 1, 0, 8'h00);
        end
        write_enb = 1'b0;
        for (int j = 0; j < 5; j++) exp_pop(0, 0, 0, 8'(8'h39 + j));
        repeat (5) tick();
        read_enb = 1'b0;
        tick();
        exp_st("rw_drained", 0, 0, 0, 0, 1, 8'h3D);

        // Underflow
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        exp_st("udf_pulse", 0, 0, 1, 0, 1, 8'h3D);
        tick();
        exp_st("udf_clear", 0, 0, 0, 0, 1, 8'h3D);

        // Mid-packet flush. The header abandons the still-open 0xFC packet.
        wr(1, 8'h08);
        wr(0, 8'h41);
        wr(0, 8'h42);
        wr(0, 8'h43);
        wr(0, 8'h50);
        wr(0, 8'h51);
        wr(0, 8'h52);
        exp_st("flush_loaded", 7, 0, 0, 0, 0, 8'h00);
        exp_pop(1, 0, 1, 8'h08);
        exp_pop(0, 0, 0, 8'h41);
        read_enb = 1'b1;
        tick();
        tick();
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        sof_in     = 1'b1;
        data_in    = 8'hAA;
        tick();
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        sof_in     = 1'b0;
        read_enb   = 1'b0;
        exp_st("soft_reset", 0, 0, 0, 0, 1, 8'h41);
        wr(1, 8'h04);
        wr(0, 8'h61);
        wr(0, 8'h62);
        exp_st("post_flush", 3, 0, 0, 0, 0, 8'h00);
        exp_pop(1, 0, 0, 8'h04);
        exp_pop(0, 0, 0, 8'h61);
        exp_pop(0, 1, 0, 8'h62);
        read_enb = 1'b1;
        repeat (3) tick();
        read_enb = 1'b0;
        tick();

        // Orphan beat after flush, then zero-length packet
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        wr(0, 8'h77);
        exp_pop(0, 0, 1, 8'h77);
        read_enb = 1'b1;
        tick();
        read_enb = 1'b0;
        wr(1, 8'h00);
        wr(0, 8'h99);
        exp_pop(1, 0, 0, 8'h00);
        exp_pop(0, 1, 0, 8'h99);
        read_enb = 1'b1;
        repeat (2) tick();
        read_enb = 1'b0;
        tick();
        exp_st("final", 0, 0, 0, 0, 1, 8'h99);
        tick();
        exp_st("end", 0, 0, 0, 0, 0, 8'h00);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
